// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct-address and autonomous scan modes.
// Scan holds each output for dwell+1 cycles and pulses wrap when the index rolls over.
module scan_decoder #(
  parameter int ADDR_WIDTH  = 2,
  parameter int DWELL_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       mode,
  input  logic                       load,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic [DWELL_WIDTH-1:0]     dwell,
  output logic [2**ADDR_WIDTH-1:0]   out,
  output logic [ADDR_WIDTH-1:0]      current,
  output logic                       wrap
);

  localparam int N_OUT = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]  LAST_IDX = {ADDR_WIDTH{1'b1}};
  localparam logic [N_OUT-1:0]       ONE_HOT0 = {{(N_OUT-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_q, cur_d;
  logic [DWELL_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    wrap_q, wrap_d;
  logic [N_OUT-1:0]        out_q, out_d;

  // Next-state: enable outranks mode, mode outranks load / dwell expiry.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (mode) begin
          state_d = SCAN;
          cur_d   = {ADDR_WIDTH{1'b0}};
          cnt_d   = dwell;
        end else begin
          state_d = DIRECT;
          cur_d   = address;
        end
      end
      DIRECT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (mode) begin
          state_d = SCAN;
          cur_d   = {ADDR_WIDTH{1'b0}};
          cnt_d   = dwell;
        end else if (load) begin
          cur_d   = address;
        end else begin
          cur_d   = cur_q;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (!mode) begin
          state_d = DIRECT;
          cur_d   = address;
        end else if (cnt_q != {DWELL_WIDTH{1'b0}}) begin
          cnt_d   = cnt_q - DWELL_WIDTH'(1);
        end else begin
          // dwell is only sampled here and on scan entry
          cur_d   = cur_q + ADDR_WIDTH'(1);
          cnt_d   = dwell;
          wrap_d  = (cur_q == LAST_IDX);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output select is derived from the next index so out always matches current.
  always_comb begin
    if (state_d == IDLE) begin
      out_d = {N_OUT{1'b0}};
    end else begin
      out_d = ONE_HOT0 << cur_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cur_q   <= {ADDR_WIDTH{1'b0}};
      cnt_q   <= {DWELL_WIDTH{1'b0}};
      wrap_q  <= 1'b0;
      out_q   <= {N_OUT{1'b0}};
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      out_q   <= out_d;
    end
  end

  assign out     = out_q;
  assign current = cur_q;
  assign wrap    = wrap_q;

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Registered, parametrised one-hot decoder with two operating modes: direct decode of an input address, or autonomous scanning through every output with a programmable dwell time. It generalises the team's 2-to-4 enable decoder to 2^ADDR_WIDTH outputs and adds a clocked state machine, a load strobe, a dwell counter and a wrap indication. It drives row/strobe selects for multiplexed displays and banked peripherals.

## Interface

Parameters:
- ADDR_WIDTH, default 2: address bits. The block has 2^ADDR_WIDTH outputs. Legal range is 1..8.
- DWELL_WIDTH, default 4: width of the dwell-count input and of the internal dwell counter.

Ports:
- clk  input  1  sole clock. All state updates on the rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- enable  input  1  block enable. Low forces IDLE.
- mode  input  1  0 = direct decode, 1 = scan.
- load  input  1  in DIRECT, capture `address` into `current`.
- address  input  ADDR_WIDTH  address used in direct mode.
- dwell  input  DWELL_WIDTH  in scan mode, each output is held for dwell+1 cycles.
- out  output  2^ADDR_WIDTH  registered one-hot select. All zero when not active.
- current  output  ADDR_WIDTH  registered index of the asserted output.
- wrap  output  1  one-cycle pulse when scan advances from the last index to 0.

## Operation

- States: IDLE, DIRECT, SCAN. Internal dwell counter `cnt` is DWELL_WIDTH bits wide.
- Reset (reset_n low, asynchronous): state=IDLE, out=0, current=0, wrap=0, cnt=0. These values hold while reset_n is low.
- All outputs are registered. `out` always equals one-hot(current) in DIRECT and SCAN, and 0 in IDLE.

IDLE:
- enable=0: stay in IDLE.
- enable=1, mode=0: go to DIRECT and load current<=address.
- enable=1, mode=1: go to SCAN, load current<=0 and cnt<=dwell.

DIRECT:
- enable=0: go to IDLE. current is retained.
- mode=1: go to SCAN, load current<=0 and cnt<=dwell.
- load=1: current<=address. With load=0, current holds.

SCAN:
- enable=0: go to IDLE.
- mode=0: go to DIRECT and load current<=address, regardless of load.
- Otherwise, while cnt≠0, cnt<=cnt-1.
- When cnt==0:
  - current<=current+1, modulo 2^ADDR_WIDTH.
  - cnt<=dwell. `dwell` is sampled only at this reload, or on SCAN entry.
  - If the old current was 2^ADDR_WIDTH-1, wrap<=1.
- In all other cycles, wrap<=0.

Priority and boundary rules:
- Priority order is reset_n, then enable, then mode, then load / dwell expiry.
- dwell=0 advances the index every cycle. dwell=2^DWELL_WIDTH-1 holds each index for 2^DWELL_WIDTH cycles.
- Address and current arithmetic wraps silently. No out-of-range index exists.
- wrap is never asserted in IDLE or DIRECT. It is cleared on the edge that leaves SCAN.
- Exactly one bit of `out` is high in DIRECT/SCAN, and none in IDLE. No glitches, since outputs come straight from flops.

## Timing

- Latency is 1 cycle. Inputs sampled at edge k appear on out/current/wrap after edge k.
- Direct mode: a load at edge k changes `out` after edge k. Back-to-back loads on consecutive cycles are each honoured.
- Scan period: each index is visible for exactly dwell+1 cycles. A full sweep is 2^ADDR_WIDTH·(dwell+1) cycles.
- wrap is high for exactly the one cycle in which current==0 first appears after index max.
- A reset deassertion is synchronised by the system. The first state change occurs on the first rising edge with reset_n high.
- Reset mid-scan clears everything immediately. After release, the block restarts from IDLE, not from the previous index.

## Test plan

- Reset/idle: assert reset_n=0 mid-SCAN at current=2. Require out=0, current=0 and wrap=0 asynchronously. With enable=0 after release, out stays 0.
- Direct decode (ADDR_WIDTH=2): enable=1, mode=0, address=3. Require out=4'b1000 one cycle later. Then load=1 with address=1, and require out=4'b0010 the next cycle. With load=0 and address changed to 2, out stays 4'b0010.
- Scan with dwell=2: require the out sequence 0001×3, 0010×3, 0100×3, 1000×3, then 0001. wrap is high only on the first 0001 cycle after 1000, and the period is 12 cycles.
- Scan with dwell=0 (ADDR_WIDTH=3): out advances every cycle through all 8 bits. wrap pulses once every 8 cycles.
- Dwell sampling: change dwell from 1 to 3 mid-index. Require the current index to finish with the old count and the next index to hold for 4 cycles.
- Mode/enable interplay: in SCAN at current=2, set mode=0 with address=0. Require out=0001 next cycle and no wrap. Then drop enable, and require out=0 next cycle. Then enable with mode=1, and require the scan to restart at index 0.
